// File: rtl/des_key_sched_ctrl.sv
// Iterative DES key schedule: PC-1 at key accept, one shared C/D rotator and PC-2 network,
// round keys issued in encrypt (K1..K16) or decrypt (K16..K1) order over a valid/ready port.
module des_key_sched_ctrl #(
    parameter bit DEC_EN  = 1'b1,
    parameter bit PAR_CHK = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        key_valid_i,
    output logic        key_ready_o,
    input  logic [63:0] key_in_i,
    input  logic        decrypt_i,
    input  logic        abort_i,
    output logic        rk_valid_o,
    input  logic        rk_ready_i,
    output logic [47:0] round_key_o,
    output logic [3:0]  rk_idx_o,
    output logic        rk_last_o,
    output logic        busy_o,
    output logic        key_err_o
);

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef enum logic {S_IDLE, S_ROUND} state_t;

    state_t      state_q, state_d;
    logic [27:0] c_q, d_q;
    logic [3:0]  cnt_q;
    logic        mode_q;
    logic        key_err_q;

    logic [55:0] pc1_w;
    logic [55:0] cd_w;
    logic [47:0] pc2_w;
    logic [7:0]  byte_odd;
    logic        accept, par_bad, hs, last_cnt, dec_sel;
    logic [4:0]  enc_r, dec_r;

    function automatic logic shift_is_one(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd2) || (r == 5'd9) || (r == 5'd16);
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic one);
        return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic one);
        return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    // Tables count bits from 1 at the MSB, hence the 64-n / 56-n mapping.
    for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
        assign pc1_w[55-gi] = key_in_i[64-PC1[gi]];
    end

    assign cd_w = {c_q, d_q};
    for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
        assign pc2_w[47-gi] = cd_w[56-PC2[gi]];
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_par
        assign byte_odd[gi] = ^key_in_i[8*gi +: 8];
    end

    assign accept   = (state_q == S_IDLE) && key_valid_i;
    assign par_bad  = PAR_CHK && !(&byte_odd);
    assign hs       = (state_q == S_ROUND) && rk_ready_i && !abort_i;
    assign last_cnt = (cnt_q == 4'd15);
    assign dec_sel  = decrypt_i && DEC_EN;
    assign enc_r    = {1'b0, cnt_q} + 5'd2;
    assign dec_r    = 5'd16 - {1'b0, cnt_q};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && !par_bad) state_d = S_ROUND;
            end
            S_ROUND: begin
                if (abort_i) state_d = S_IDLE;
                else if (hs && last_cnt) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Decrypt starts from CD0 (== CD16) and walks backwards with right rotations.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            c_q       <= '0;
            d_q       <= '0;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            key_err_q <= 1'b0;
        end else begin
            key_err_q <= accept && par_bad;
            if (accept && !par_bad) begin
                mode_q <= dec_sel;
                cnt_q  <= '0;
                if (dec_sel) begin
                    c_q <= pc1_w[55:28];
                    d_q <= pc1_w[27:0];
                end else begin
                    c_q <= rotl28(pc1_w[55:28], 1'b1);
                    d_q <= rotl28(pc1_w[27:0], 1'b1);
                end
            end else if (hs && !last_cnt) begin
                cnt_q <= cnt_q + 4'd1;
                if (mode_q) begin
                    c_q <= rotr28(c_q, shift_is_one(dec_r));
                    d_q <= rotr28(d_q, shift_is_one(dec_r));
                end else begin
                    c_q <= rotl28(c_q, shift_is_one(enc_r));
                    d_q <= rotl28(d_q, shift_is_one(enc_r));
                end
            end
        end
    end

    always_comb begin
        key_ready_o = 1'b0;
        rk_valid_o  = 1'b0;
        busy_o      = 1'b0;
        round_key_o = '0;
        rk_idx_o    = '0;
        rk_last_o   = 1'b0;
        key_err_o   = key_err_q;
        if (state_q == S_ROUND) begin
            rk_valid_o  = 1'b1;
            busy_o      = 1'b1;
            round_key_o = pc2_w;
            rk_idx_o    = mode_q ? (4'd15 - cnt_q) : cnt_q;
            rk_last_o   = last_cnt;
        end else begin
            key_ready_o = 1'b1;
        end
    end

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Scoreboard bench for des_key_sched_ctrl: textbook DES key-schedule model feeds an expected
// queue; a negedge monitor pops and compares on every round-key handshake.
`timescale 1ns/1ps
module tb_des_key_sched_ctrl;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic        key_ready;
    logic [63:0] key_in = '0;
    logic        decrypt = 1'b0;
    logic        abort = 1'b0;
    logic        rk_valid;
    logic        rk_ready = 1'b1;
    logic [47:0] round_key;
    logic [3:0]  rk_idx;
    logic        rk_last;
    logic        busy;
    logic        key_err;

    typedef struct packed {
        logic [47:0] key;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   err_expect = 0;
    int   job_hs = 0;
    int   abort_hs_count = -1;
    logic stall_en = 1'b0;

    always #5 clk = ~clk;

    des_key_sched_ctrl #(.DEC_EN(1'b1), .PAR_CHK(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .key_valid_i(key_valid), .key_ready_o(key_ready),
        .key_in_i(key_in), .decrypt_i(decrypt), .abort_i(abort), .rk_valid_o(rk_valid),
        .rk_ready_i(rk_ready), .round_key_o(round_key), .rk_idx_o(rk_idx),
        .rk_last_o(rk_last), .busy_o(busy), .key_err_o(key_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic par_ok(input logic [63:0] k);
        for (int b = 0; b < 8; b++)
            if (^k[8*b +: 8] == 1'b0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [63:0] fix_par(input logic [63:0] k);
        logic [63:0] r = k;
        for (int b = 0; b < 8; b++) r[8*b] = ~(^k[8*b+1 +: 7]);
        return r;
    endfunction

    // Textbook schedule: C_r, D_r from C_{r-1}, D_{r-1} by left shifts; K_r = PC-2(C_r D_r).
    task automatic push_job(input logic [63:0] key, input logic dec);
        logic [55:0] p;
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] ks [16];
        exp_t e;
        for (int i = 0; i < 56; i++) p[55-i] = key[64-PC1_T[i]];
        c = p[55:28];
        d = p[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SHIFTS[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int j = 0; j < 48; j++) ks[r][47-j] = cd[56-PC2_T[j]];
        end
        for (int j = 0; j < 16; j++) begin
            e.key  = dec ? ks[15-j] : ks[j];
            e.idx  = 4'(dec ? 15 - j : j);
            e.last = (j == 15);
            exp_q.push_back(e);
        end
    endtask

    // Returns at posedge+1 just after the accepting edge.
    task automatic start_job(input logic [63:0] key, input logic dec);
        int t = 0;
        while (!key_ready && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        check("wait_key_ready_timeout", 64'(t >= 2000), 64'd0);
        key_valid = 1'b1;
        key_in    = key;
        decrypt   = dec;
        @(negedge clk);
        if (par_ok(key)) push_job(key, dec);
        else err_expect++;
        @(posedge clk); #1;
        key_valid = 1'b0;
        abort     = 1'b0;
        key_in    = {$urandom, $urandom};
        decrypt   = $urandom_range(0, 1) == 1;
        $display("[TB] job key=0x%016h dec=%0d", key, dec);
    endtask

    task automatic wait_done();
        int t = 0;
        while ((exp_q.size() != 0 || !key_ready) && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        check("job_done_timeout", 64'(t >= 3000), 64'd0);
    endtask

    initial begin : rk_ready_drv
        forever begin
            @(posedge clk); #1;
            rk_ready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    initial begin : monitor
        exp_t e, prev;
        logic prev_stall = 1'b0;
        logic prev_abort = 1'b0;
        logic prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                job_hs = 0;
                prev_stall = 1'b0;
                prev_abort = 1'b0;
                prev_last = 1'b0;
                continue;
            end
            if (prev_abort) check("abort_drops_valid", 64'(rk_valid), 64'd0);
            if (prev_last) begin
                check("ready_after_last", 64'(key_ready), 64'd1);
                check("idle_after_last", 64'(busy), 64'd0);
            end
            if (prev_stall) begin
                check("stall_valid_held", 64'(rk_valid), 64'd1);
                check("stall_key_held", 64'(round_key), 64'(prev.key));
                check("stall_idx_held", 64'(rk_idx), 64'(prev.idx));
                check("stall_last_held", 64'(rk_last), 64'(prev.last));
            end
            prev_stall = 1'b0;
            prev_abort = 1'b0;
            prev_last = 1'b0;
            check("ready_vs_busy", 64'(key_ready), 64'(!busy));
            if (key_err) begin
                check("key_err_expected", 64'(err_expect > 0), 64'd1);
                if (err_expect > 0) err_expect--;
            end
            if (rk_valid && abort) begin
                abort_hs_count = job_hs;
                job_hs = 0;
                exp_q.delete();
                prev_abort = 1'b1;
            end else if (rk_valid) begin
                check("valid_with_pending_job", 64'(exp_q.size() > 0), 64'd1);
                if (rk_ready && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    job_hs++;
                    check("round_key", 64'(round_key), 64'(e.key));
                    check("rk_idx", 64'(rk_idx), 64'(e.idx));
                    check("rk_last", 64'(rk_last), 64'(e.last));
                    if (rk_last) begin
                        check("handshakes_per_job", 64'(job_hs), 64'd16);
                        job_hs = 0;
                        prev_last = 1'b1;
                    end
                end else if (!rk_ready) begin
                    prev_stall = 1'b1;
                    prev.key = round_key;
                    prev.idx = rk_idx;
                    prev.last = rk_last;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [63:0] k;
        repeat (2) @(posedge clk);
        #1;
        check("reset_key_ready", 64'(key_ready), 64'd1);
        check("reset_rk_valid", 64'(rk_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_round_key", 64'(round_key), 64'd0);
        check("reset_rk_idx", 64'(rk_idx), 64'd0);
        check("reset_rk_last", 64'(rk_last), 64'd0);
        check("reset_key_err", 64'(key_err), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Known-answer encrypt run
        start_job(64'h133457799BBCDFF1, 1'b0);
        check("enc_first_valid", 64'(rk_valid), 64'd1);
        check("enc_first_key", 64'(round_key), 64'h1B02EFFC7072);
        check("enc_first_idx", 64'(rk_idx), 64'd0);
        repeat (15) @(posedge clk);
        #1;
        check("enc_last_key", 64'(round_key), 64'hCB3D8B0E17F5);
        check("enc_last_flag", 64'(rk_last), 64'd1);
        @(posedge clk); #1;
        check("enc_ready_next", 64'(key_ready), 64'd1);
        wait_done();

        // Known-answer decrypt run
        start_job(64'h133457799BBCDFF1, 1'b1);
        check("dec_first_key", 64'(round_key), 64'hCB3D8B0E17F5);
        check("dec_first_idx", 64'(rk_idx), 64'd15);
        repeat (15) @(posedge clk);
        #1;
        check("dec_last_key", 64'(round_key), 64'h1B02EFFC7072);
        check("dec_last_idx", 64'(rk_idx), 64'd0);
        check("dec_last_flag", 64'(rk_last), 64'd1);
        wait_done();

        // Random keys with random back-pressure
        stall_en = 1'b1;
        for (int n = 0; n < 100; n++) begin
            k = fix_par({$urandom, $urandom});
            start_job(k, $urandom_range(0, 1) == 1);
            wait_done();
        end
        stall_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Abort on the 5th handshake cycle
        start_job(fix_par({$urandom, $urandom}), $urandom_range(0, 1) == 1);
        repeat (4) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_valid_low", 64'(rk_valid), 64'd0);
        check("abort_hs_count", 64'(abort_hs_count), 64'd4);
        start_job(fix_par({$urandom, $urandom}), $urandom_range(0, 1) == 1);
        wait_done();

        // Abort in IDLE does not block a key
        abort = 1'b1;
        start_job(fix_par({$urandom, $urandom}), 1'b0);
        check("idle_abort_ignored", 64'(rk_valid), 64'd1);
        wait_done();

        // Parity failure, then a good key
        start_job(64'h133457799BBCDFF0, 1'b0);
        check("par_err_pulse", 64'(key_err), 64'd1);
        check("par_err_no_valid", 64'(rk_valid), 64'd0);
        check("par_err_idle", 64'(key_ready), 64'd1);
        @(posedge clk); #1;
        check("par_err_one_cycle", 64'(key_err), 64'd0);
        check("par_err_still_idle", 64'(rk_valid), 64'd0);
        start_job(64'h133457799BBCDFF1, 1'b0);
        check("par_ok_no_err", 64'(key_err), 64'd0);
        check("par_ok_valid", 64'(rk_valid), 64'd1);
        wait_done();

        // Asynchronous reset mid-job at cnt=7
        start_job(fix_par({$urandom, $urandom}), $urandom_range(0, 1) == 1);
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_rk_valid", 64'(rk_valid), 64'd0);
        check("rst_key_ready", 64'(key_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_round_key", 64'(round_key), 64'd0);
        check("rst_rk_idx", 64'(rk_idx), 64'd0);
        check("rst_rk_last", 64'(rk_last), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("post_rst_ready", 64'(key_ready), 64'd1);
            check("post_rst_no_valid", 64'(rk_valid), 64'd0);
        end

        check("err_pending", 64'(err_expect), 64'd0);
        check("exp_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
